// File: rtl/carry_digit_display_pkg.sv
// carry_digit_display_pkg
// Shared constants for the carry digit display: hex-to-segment glyph table
// (active-low {dp,g,f,e,d,c,b,a}, dp always off), blank segment pattern and
// all-anodes-off pattern.
package carry_digit_display_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] AN_OFF    = 4'hF;

  // Entry n is the glyph for hex digit n (entry 15 listed first).
  localparam logic [15:0][7:0] HEX_SEG = {
    8'h8E, 8'h86, 8'hA1, 8'hC6,   // F E d C
    8'h83, 8'h88, 8'h90, 8'h80,   // b A 9 8
    8'hF8, 8'h82, 8'h92, 8'h99,   // 7 6 5 4
    8'hB0, 8'hA4, 8'hF9, 8'hC0    // 3 2 1 0
  };

  function automatic logic [7:0] hex_glyph(input logic [3:0] hex);
    return HEX_SEG[hex];
  endfunction

endpackage

// File: rtl/carry_digit_display_if.sv
// carry_digit_display_if
// Bundles the upstream counter inputs (Qa..Qd, Rc), the clear, and the
// display/value outputs.
//   master : testbench / upstream side (drives clr, Q*, Rc)
//   slave  : carry_digit_display side (drives value, ovf, an, seg)
interface carry_digit_display_if;
  logic        clr;
  logic        Qa;
  logic        Qb;
  logic        Qc;
  logic        Qd;
  logic        Rc;
  logic [15:0] value;
  logic        ovf;
  logic [3:0]  an;
  logic [7:0]  seg;

  modport master (
    output clr, Qa, Qb, Qc, Qd, Rc,
    input  value, ovf, an, seg
  );

  modport slave (
    input  clr, Qa, Qb, Qc, Qd, Rc,
    output value, ovf, an, seg
  );
endinterface

// File: rtl/carry_digit_display_hex_to_seg7.sv
// hex_to_seg7
// Combinational hex digit to active-low 7-segment glyph (dp off).
//   hex   : 4-bit digit in
//   seg_n : {dp,g,f,e,d,c,b,a}, active-low
module hex_to_seg7
  import carry_digit_display_pkg::*;
(
  input  logic [3:0] hex,
  output logic [7:0] seg_n
);
  assign seg_n = hex_glyph(hex);
endmodule

// File: rtl/carry_digit_display.sv
// carry_digit_display
// Extends an upstream 4-bit counter with three upper hex digits (U), counting
// one per rising edge of the upstream ripple carry, and multiplexes the four
// digits onto a common-anode 7-segment display.
//   clk   : system clock (same as upstream counter)
//   rst_n : async active-low reset
//   bus   : slave modport -- clr, Qa..Qd, Rc in; value, ovf, an, seg out
// Parameter SCAN_W (>= 3): scan counter width; top two bits select the digit.
// Macro LEADING_ZERO_BLANK_EN: blank upper digits that are leading zeros.
module carry_digit_display
  import carry_digit_display_pkg::*;
#(
  parameter int SCAN_W = 17
) (
  input  logic                 clk,
  input  logic                 rst_n,
  carry_digit_display_if.slave bus
);

  localparam logic [SCAN_W-1:0] S_ONE = {{(SCAN_W-1){1'b0}}, 1'b1};

  logic [11:0]       u_q, u_d;
  logic              rc_q;
  logic              ovf_q, ovf_d;
  logic [SCAN_W-1:0] s_q, s_d;
  logic [3:0]        an_q, an_d;
  logic [7:0]        seg_q, seg_d;

  logic [15:0] value_w;
  logic        carry_evt;
  logic [1:0]  digit_sel;
  logic [3:0]  nibble;
  logic [7:0]  glyph;
  logic        blank;

  assign value_w   = {u_q, bus.Qd, bus.Qc, bus.Qb, bus.Qa};
  assign carry_evt = bus.Rc & ~rc_q;
  assign digit_sel = s_q[SCAN_W-1 -: 2];

  assign bus.value = value_w;
  assign bus.ovf   = ovf_q;
  assign bus.an    = an_q;
  assign bus.seg   = seg_q;

  hex_to_seg7 u_hex_to_seg7 (
    .hex   (nibble),
    .seg_n (glyph)
  );

  // Upper count; clear wins over a simultaneous carry.
  always_comb begin
    u_d   = u_q;
    ovf_d = 1'b0;
    if (bus.clr) begin
      u_d = 12'h000;
    end else if (carry_evt) begin
      u_d   = u_q + 12'd1;
      ovf_d = (u_q == 12'hFFF);
    end
  end

  always_comb begin
    s_d = s_q + S_ONE;
    case (digit_sel)
      2'd0:    nibble = value_w[3:0];
      2'd1:    nibble = value_w[7:4];
      2'd2:    nibble = value_w[11:8];
      default: nibble = value_w[15:12];
    endcase
  end

  // A digit is a leading zero when it and every digit above it are zero.
  always_comb begin
    blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    case (digit_sel)
      2'd1:    blank = (u_q == 12'h000);
      2'd2:    blank = (u_q[11:4] == 8'h00);
      2'd3:    blank = (u_q[11:8] == 4'h0);
      default: blank = 1'b0;
    endcase
`endif
    an_d  = blank ? AN_OFF : ~(4'b0001 << digit_sel);
    seg_d = blank ? SEG_BLANK : glyph;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u_q   <= 12'h000;
      rc_q  <= 1'b0;
      ovf_q <= 1'b0;
      s_q   <= '0;
      an_q  <= AN_OFF;
      seg_q <= SEG_BLANK;
    end else begin
      u_q   <= u_d;
      rc_q  <= bus.Rc;
      ovf_q <= ovf_d;
      s_q   <= s_d;
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

endmodule

// File: tb/tb_carry_digit_display.sv
// tb_carry_digit_display
// Randomised and directed stimulus for carry_digit_display (SCAN_W = 3 so the
// digit scan turns over quickly). A reference model predicts value, ovf and
// the registered an/seg for every clock; a monitor compares them one cycle
// later. Honours LEADING_ZERO_BLANK_EN for the expected blanking.
module tb_carry_digit_display;

  localparam int TB_SCAN_W = 3;

  localparam logic [7:0] GLYPH [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  typedef struct packed {
    logic [15:0] value;
    logic        ovf;
    logic [3:0]  an;
    logic [7:0]  seg;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  carry_digit_display_if bus ();

  carry_digit_display #(.SCAN_W(TB_SCAN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // reference model state
  int u_m   = 0;
  bit rc_prev = 1'b0;
  int cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: one expectation per modelled clock, sampled 1 time unit after the edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_vec++;
      if (bus.value !== e.value || bus.ovf !== e.ovf || bus.an !== e.an || bus.seg !== e.seg) begin
        n_err++;
        $display("FAIL cycle_out t=%0t: value=%h ovf=%b an=%b seg=%h expected value=%h ovf=%b an=%b seg=%h",
                 $time, bus.value, bus.ovf, bus.an, bus.seg, e.value, e.ovf, e.an, e.seg);
      end
    end
  end

  // Apply one cycle of inputs and predict the outputs after the next edge.
  task automatic step(input bit clr_i, input int q_i, input bit rc_i);
    logic [15:0] prev;
    logic [3:0]  dig;
    int          k;
    bit          blank;
    exp_t        e;
    @(negedge clk);
    bus.clr = clr_i;
    {bus.Qd, bus.Qc, bus.Qb, bus.Qa} = 4'(q_i);
    bus.Rc = rc_i;
    @(posedge clk);
    prev  = {u_m[11:0], 4'(q_i)};
    k     = (cyc >> (TB_SCAN_W - 2)) % 4;
    cyc++;
    dig   = prev[4*k +: 4];
    blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    if (k != 0 && (prev >> (4*k)) == 16'd0) blank = 1'b1;
`endif
    e.an  = blank ? 4'hF : ~(4'b0001 << k);
    e.seg = blank ? 8'hFF : GLYPH[dig];
    e.ovf = 1'b0;
    if (clr_i) begin
      u_m = 0;
    end else if (rc_i && !rc_prev) begin
      if (u_m == 4095) begin
        u_m   = 0;
        e.ovf = 1'b1;
      end else begin
        u_m = u_m + 1;
      end
    end
    rc_prev = rc_i;
    e.value = {u_m[11:0], 4'(q_i)};
    exp_q.push_back(e);
  endtask

  task automatic carries(input int n);
    repeat (n) begin
      step(1'b0, 0, 1'b1);
      step(1'b0, 0, 1'b0);
    end
  endtask

  // Async reset between edges; outputs must clear without waiting for a clock.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n  = 1'b0;
    bus.clr = 1'b0;
    {bus.Qd, bus.Qc, bus.Qb, bus.Qa} = 4'h0;
    bus.Rc = 1'b0;
    #1;
    check("rst_an", 32'(bus.an), 32'hF);
    check("rst_seg", 32'(bus.seg), 32'hFF);
    check("rst_upper", 32'(bus.value[15:4]), 32'h0);
    check("rst_ovf", 32'(bus.ovf), 32'h0);
    u_m = 0;
    rc_prev = 1'b0;
    cyc = 0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    bus.clr = 1'b0;
    bus.Qa = 1'b0; bus.Qb = 1'b0; bus.Qc = 1'b0; bus.Qd = 1'b0;
    bus.Rc = 1'b0;

    do_reset();

    // Upstream 0..F counter for 40 cycles, Rc while at F.
    for (int i = 0; i < 40; i++) step(1'b0, i % 16, (i % 16) == 15);
    #2;
    check("count40_value", 32'(bus.value), 32'h0027);

    // Rc held for 5 cycles counts once.
    do_reset();
    repeat (5) step(1'b0, 15, 1'b1);
    step(1'b0, 0, 1'b0);
    #2;
    check("rc_held_upper", 32'(bus.value[15:4]), 32'h001);

    // Random traffic.
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 29) == 0, int'($urandom_range(0, 15)), $urandom_range(0, 1) == 1);

    // clr coinciding with a carry edge at U = 5.
    do_reset();
    carries(5);
    step(1'b1, 0, 1'b1);
    #2;
    check("clr_upper", 32'(bus.value[15:4]), 32'h000);
    check("clr_ovf", 32'(bus.ovf), 32'h0);
    step(1'b0, 0, 1'b0);

    // Upper digit display with leading zeros: value = 16'h00A3.
    do_reset();
    carries(10);
    repeat (20) step(1'b0, 3, 1'b0);

    // Wrap from 12'hFFF.
    do_reset();
    carries(4095);
    #2;
    check("preload_upper", 32'(bus.value[15:4]), 32'hFFF);
    step(1'b0, 0, 1'b1);
    #2;
    check("wrap_upper", 32'(bus.value[15:4]), 32'h000);
    check("wrap_ovf_hi", 32'(bus.ovf), 32'h1);
    step(1'b0, 0, 1'b0);
    #2;
    check("wrap_ovf_lo", 32'(bus.ovf), 32'h0);

    // Reset mid-scan with U = 12'h123.
    do_reset();
    carries(291);
    step(1'b0, 7, 1'b0);
    step(1'b0, 7, 1'b0);
    #2;
    check("pre_rst_upper", 32'(bus.value[15:4]), 32'h123);
    do_reset();
    repeat (12) step(1'b0, int'($urandom_range(0, 15)), 1'b0);

    @(posedge clk);
    #3;
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
